tr_defuzzy_iter: RTL



---
 rtl/tr_defuzzy_pkg.sv | 28 ++
 rtl/tr_defuzzy_iter_div.sv | 96 +++++++++
 rtl/tr_defuzzy_iter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/tr_defuzzy_pkg.sv
// tr_defuzzy_pkg
//   Shared definitions for the iterative type-reduction / defuzzification
//   stage: FSM state encoding, accumulator width helpers and the default
//   centroid positions / zero-weight output.
package tr_defuzzy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_DIV,
        ST_DONE
    } state_t;

    // Numerator holds sum of N products of (W+1)-bit weight by W-bit position.
    function automatic int num_w(input int w, input int n);
        return 2 * w + 1 + $clog2(n);
    endfunction

    // Denominator holds sum of N (W+1)-bit weights.
    function automatic int den_w(input int w, input int n);
        return w + 1 + $clog2(n);
    endfunction

    // Set i sits at bits [i*8 +: 8]: set0=0, set1=128, set2=255.
    localparam logic [23:0] POS_DEFAULT      = {8'd255, 8'd128, 8'd0};
    localparam logic [7:0]  ZERO_OUT_DEFAULT = 8'd128;

endpackage

// File: rtl/tr_defuzzy_iter_div.sv
// div_restoring_seq
//   Sequential restoring divider, one quotient bit per enabled cycle, MSB
//   first, QW cycles after start. The quotient is assumed to fit in QW bits;
//   if it does not, the result saturates to all-ones.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   i_en       clock enable; state only advances when high
//   i_start    load operands (sampled only when i_en)
//   i_num      dividend, NW bits
//   i_den      divisor, DW bits (non-zero)
//   o_busy     division in progress
//   o_done     high in the enabled cycle that produces the last bit
//   o_quot     quotient; valid while o_done is high
import tr_defuzzy_pkg::*;

module div_restoring_seq #(
    parameter int NW = 19,
    parameter int DW = 11,
    parameter int QW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic          i_start,
    input  logic [NW-1:0] i_num,
    input  logic [DW-1:0] i_den,
    output logic          o_busy,
    output logic          o_done,
    output logic [QW-1:0] o_quot
);

    localparam int CW = $clog2(QW + 1);

    logic [DW-1:0] r_rem;
    logic [DW-1:0] r_den;
    logic [QW-1:0] r_nlo;
    logic [QW-1:0] r_q;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_ovf;

    logic [DW:0]   w_trial;
    logic          w_ge;
    logic [DW-1:0] w_rem_next;
    logic          w_last;
    logic          w_ovf;

    // Only QW iterations are run: the partial remainder starts as the upper
    // NW-QW dividend bits, which is below the divisor whenever the quotient
    // fits in QW bits. Otherwise the result is forced to all-ones.
    assign w_ovf = (i_num >> QW) >= NW'(i_den);

    always_comb begin
        w_trial    = {r_rem, r_nlo[QW-1]};
        w_ge       = (w_trial >= {1'b0, r_den});
        w_rem_next = w_ge ? DW'(w_trial - {1'b0, r_den}) : DW'(w_trial);
        w_last     = r_busy && (r_cnt == CW'(QW - 1));
    end

    // Done and the final quotient are combinational so the caller can
    // capture them on the same edge as the last iteration.
    assign o_busy = r_busy;
    assign o_done = w_last && i_en;
    assign o_quot = r_ovf ? '1 : {r_q[QW-2:0], w_ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= '0;
            r_den  <= '0;
            r_nlo  <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (i_en) begin
            if (i_start) begin
                r_rem  <= DW'(i_num >> QW);
                r_nlo  <= i_num[QW-1:0];
                r_den  <= i_den;
                r_q    <= '0;
                r_cnt  <= '0;
                r_busy <= 1'b1;
                r_ovf  <= w_ovf;
            end else if (r_busy) begin
                r_rem <= w_rem_next;
                r_nlo <= {r_nlo[QW-2:0], 1'b0};
                r_q   <= {r_q[QW-2:0], w_ge};
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/tr_defuzzy_iter.sv
// tr_defuzzy_iter
//   Iterative interval type-2 type reduction and centroid defuzzification.
//   Each set's weight is fou_up + fou_low; the crisp output is
//   floor(sum(w_i*POS_i) / sum(w_i)), or ZERO_OUT when the total weight is 0.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   EN_SCLK             clock enable for all state
//   in_valid/in_ready   input handshake (fou_up, fou_low captured on accept)
//   fou_up, fou_low     N packed W-bit firing strengths, set i at [i*W +: W]
//   saida               registered crisp output
//   out_valid/out_ready output handshake
//   div_zero            last result came from a zero denominator
import tr_defuzzy_pkg::*;

module tr_defuzzy_iter #(
    parameter int             W        = 8,
    parameter int             N        = 3,
    parameter logic [N*W-1:0] POS      = POS_DEFAULT,
    parameter logic [W-1:0]   ZERO_OUT = ZERO_OUT_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           EN_SCLK,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] fou_up,
    input  logic [N*W-1:0] fou_low,
    output logic [W-1:0]   saida,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           div_zero
);

    localparam int NW = num_w(W, N);
    localparam int DW = den_w(W, N);
    localparam int IW = $clog2(N);

    state_t         r_state;
    state_t         w_state_next;

    logic [N*W-1:0] r_up;
    logic [N*W-1:0] r_low;
    logic [IW-1:0]  r_idx;
    logic [NW-1:0]  r_num;
    logic [DW-1:0]  r_den;
    logic [W-1:0]   r_saida;
    logic           r_div_zero;

    logic [W-1:0]   w_up_sel;
    logic [W-1:0]   w_low_sel;
    logic [W-1:0]   w_pos_sel;
    logic [W:0]     w_s;
    logic [2*W:0]   w_prod;
    logic [NW-1:0]  w_num_next;
    logic [DW-1:0]  w_den_next;
    logic           w_acc_last;
    logic           w_in_ready;
    logic           w_out_valid;
    logic           w_div_start;
    logic           w_div_busy;
    logic           w_div_done;
    logic [W-1:0]   w_quot;

    // One set per enabled ACC cycle
    always_comb begin
        w_up_sel   = r_up[r_idx*W +: W];
        w_low_sel  = r_low[r_idx*W +: W];
        w_pos_sel  = POS[r_idx*W +: W];
        w_s        = {1'b0, w_up_sel} + {1'b0, w_low_sel};
        w_prod     = (2*W+1)'(w_s) * (2*W+1)'(w_pos_sel);
        w_num_next = r_num + NW'(w_prod);
        w_den_next = r_den + DW'(w_s);
        w_acc_last = (r_idx == IW'(N - 1));
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_div_start  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid && EN_SCLK) begin
                    w_state_next = ST_ACC;
                end
            end
            ST_ACC: begin
                if (EN_SCLK && w_acc_last) begin
                    if (w_den_next != '0) begin
                        // Divider loads the final sums on the same edge.
                        w_div_start  = 1'b1;
                        w_state_next = ST_DIV;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_DIV: begin
                if (w_div_done) begin
                    w_state_next = ST_DONE;
                end else if (!w_div_busy) begin
                    // Divider idle while in DIV cannot happen in normal flow;
                    // recover rather than hang.
                    w_state_next = ST_IDLE;
                end
            end
            ST_DONE: begin
                w_out_valid = 1'b1;
                if (out_ready && EN_SCLK) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (EN_SCLK) begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_up       <= '0;
            r_low      <= '0;
            r_idx      <= '0;
            r_num      <= '0;
            r_den      <= '0;
            r_saida    <= '0;
            r_div_zero <= 1'b0;
        end else if (EN_SCLK) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_up  <= fou_up;
                        r_low <= fou_low;
                        r_num <= '0;
                        r_den <= '0;
                        r_idx <= '0;
                    end
                end
                ST_ACC: begin
                    r_num <= w_num_next;
                    r_den <= w_den_next;
                    r_idx <= w_acc_last ? '0 : r_idx + 1'b1;
                    if (w_acc_last && (w_den_next == '0)) begin
                        r_saida    <= ZERO_OUT;
                        r_div_zero <= 1'b1;
                    end
                end
                ST_DIV: begin
                    if (w_div_done) begin
                        r_saida    <= w_quot;
                        r_div_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    div_restoring_seq #(
        .NW(NW),
        .DW(DW),
        .QW(W)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .i_en    (EN_SCLK),
        .i_start (w_div_start),
        .i_num   (w_num_next),
        .i_den   (w_den_next),
        .o_busy  (w_div_busy),
        .o_done  (w_div_done),
        .o_quot  (w_quot)
    );

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign saida     = r_saida;
    assign div_zero  = r_div_zero;

endmodule
